// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 message-schedule controller: FSM encoding and datapath widths.
package sha256_pkg;

  localparam int BLK_W  = 512;
  localparam int WORD_W = 32;

  localparam logic [5:0] ROUND_LAST = 6'd63;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUNDS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/sha256_w_ctrl.sv
// Sequences one 512-bit block through the external W memory, handing rounds 0..63 to the core.
// Optional abort input when SHA256_W_CTRL_ABORT_EN is defined.
module sha256_w_ctrl
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  output logic [BLK_W-1:0]  wmem_block,
  output logic              wmem_init,
  output logic              wmem_next,
  input  logic [WORD_W-1:0] wmem_w,
  output logic [WORD_W-1:0] w_out,
  output logic [5:0]        w_round,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              done,
  output logic [31:0]       blk_count
`ifdef SHA256_W_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  logic [1:0]  state_q;
  logic [5:0]  round_q;
  logic [31:0] count_q;
  logic        abort_i;
  logic        in_idle;
  logic        in_rounds;
  logic        in_done;
  logic        kill;
  logic        consume;

`ifdef SHA256_W_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign in_idle   = (state_q == ST_IDLE);
  assign in_rounds = (state_q == ST_ROUNDS);
  assign in_done   = (state_q == ST_DONE);
  assign kill      = abort_i && !in_idle;
  assign consume   = in_rounds && w_ready;

  // Handshake outputs are gated by reset_n so nothing fires while reset is held.
  assign blk_ready  = reset_n && in_idle;
  assign wmem_init  = blk_ready && blk_valid;
  assign wmem_next  = reset_n && consume && !kill && (round_q != ROUND_LAST);
  assign w_valid    = reset_n && in_rounds;
  assign w_round    = in_rounds ? round_q : 6'd0;
  assign done       = reset_n && in_done && !kill;
  assign wmem_block = blk_data;
  assign w_out      = wmem_w;
  assign blk_count  = count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      round_q <= 6'd0;
      count_q <= 32'd0;
    end else if (kill) begin
      state_q <= ST_IDLE;
      round_q <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_valid) begin
            state_q <= ST_ROUNDS;
            round_q <= 6'd0;
          end
        end
        ST_ROUNDS: begin
          if (consume) begin
            if (round_q == ROUND_LAST) begin
              state_q <= ST_DONE;
            end else begin
              round_q <= round_q + 6'd1;
            end
          end
        end
        ST_DONE: begin
          count_q <= count_q + 32'd1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          round_q <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_w_ctrl.sv
// Randomised bench for sha256_w_ctrl against a transaction-level model of the round sequencing.
module tb_sha256_w_ctrl;

  logic         clk;
  logic         reset_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic [511:0] wmem_block;
  logic         wmem_init;
  logic         wmem_next;
  logic [31:0]  wmem_w;
  logic [31:0]  w_out;
  logic [5:0]   w_round;
  logic         w_valid;
  logic         w_ready;
  logic         done;
  logic [31:0]  blk_count;
  logic         abort;

  sha256_w_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .wmem_block (wmem_block),
    .wmem_init  (wmem_init),
    .wmem_next  (wmem_next),
    .wmem_w     (wmem_w),
    .w_out      (w_out),
    .w_round    (w_round),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .done       (done),
    .blk_count  (blk_count)
`ifdef SHA256_W_CTRL_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: is a block in flight, which round is offered, is a done owed.
  bit       m_busy;
  bit       m_done_due;
  int       m_round;
  int       m_count;

  int       cyc;
  int       init_cyc;
  int       done_cyc;
  int       nexts;
  bit       saw_done;
  bit       saw_init;
  bit       rand_rdy;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    bit ab;
    bit e_idle;
    bit kill;
    bit cons;
    for (int i = 0; i < 16; i++) blk_data[i*32 +: 32] = $urandom;
    wmem_w = $urandom;
    if (rand_rdy) w_ready = 1'($urandom_range(0, 1));
`ifdef SHA256_W_CTRL_ABORT_EN
    ab = abort;
`else
    ab = 1'b0;
`endif
    #4;
    chk("w_out", {480'd0, w_out}, {480'd0, wmem_w});
    chk("wmem_block", wmem_block, blk_data);
    if (!reset_n) begin
      chk("rst_blk_ready", {511'd0, blk_ready}, 512'd0);
      chk("rst_wmem_init", {511'd0, wmem_init}, 512'd0);
      chk("rst_wmem_next", {511'd0, wmem_next}, 512'd0);
      chk("rst_w_valid", {511'd0, w_valid}, 512'd0);
      chk("rst_done", {511'd0, done}, 512'd0);
      m_busy = 0; m_done_due = 0; m_round = 0; m_count = 0;
    end else begin
      e_idle = !m_busy && !m_done_due;
      kill   = ab && !e_idle;
      cons   = m_busy && w_ready;
      chk("blk_ready", {511'd0, blk_ready}, {511'd0, e_idle});
      chk("wmem_init", {511'd0, wmem_init}, {511'd0, e_idle && blk_valid});
      chk("w_valid", {511'd0, w_valid}, {511'd0, m_busy});
      chk("w_round", {506'd0, w_round}, m_busy ? 512'(m_round) : 512'd0);
      chk("wmem_next", {511'd0, wmem_next}, {511'd0, cons && !kill && m_round < 63});
      chk("done", {511'd0, done}, {511'd0, m_done_due && !kill});
      chk("blk_count", {480'd0, blk_count}, 512'(m_count));
      if (wmem_init) begin init_cyc = cyc; nexts = 0; saw_init = 1; end
      if (wmem_next) nexts++;
      if (done) begin done_cyc = cyc; saw_done = 1; end
      if (kill) begin
        m_busy = 0; m_done_due = 0; m_round = 0;
      end else if (m_done_due) begin
        m_done_due = 0; m_count++;
      end else if (cons) begin
        if (m_round == 63) begin m_busy = 0; m_done_due = 1; end
        else m_round++;
      end else if (e_idle && blk_valid) begin
        m_busy = 1; m_round = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int limit);
    saw_done = 0;
    for (int i = 0; i < limit && !saw_done; i++) step();
    chk("done_timeout", {511'd0, saw_done}, 512'd1);
  endtask

  task automatic run_to_round(input int r, input int limit);
    int i;
    i = 0;
    while (!(m_busy && m_round == r) && i < limit) begin step(); i++; end
    chk("round_reach_timeout", {511'd0, (m_busy && m_round == r)}, 512'd1);
  endtask

  int first_init;

  initial begin
    cyc = 0; rand_rdy = 0; abort = 0; init_cyc = 0; done_cyc = 0; nexts = 0;
    saw_done = 0; saw_init = 0;
    m_busy = 0; m_done_due = 0; m_round = 0; m_count = 0;
    reset_n = 0; blk_valid = 1; w_ready = 0; blk_data = '0; wmem_w = '0;
    repeat (3) step();
    reset_n = 1; blk_valid = 0;
    repeat (4) step();
    chk("idle_count", {480'd0, blk_count}, 512'd0);

    // Single block, core always ready: exact latency.
    w_ready = 1; blk_valid = 1;
    step();
    blk_valid = 0;
    wait_done(200);
    chk("done_latency", 512'(done_cyc - init_cyc), 512'd65);
    chk("next_count_1", 512'(nexts), 512'd63);
    chk("count_1", {480'd0, blk_count}, 512'd1);
    step();

    // Random stalls on the core side.
    rand_rdy = 1; blk_valid = 1;
    step();
    blk_valid = 0;
    wait_done(1000);
    chk("next_count_stall", 512'(nexts), 512'd63);
    rand_rdy = 0; w_ready = 1;
    step();
    chk("count_2", {480'd0, blk_count}, 512'd2);

    // blk_valid held: second block accepted only once IDLE is back.
    blk_valid = 1;
    step();
    first_init = init_cyc;
    wait_done(200);
    step();
    chk("b2b_init", 512'(init_cyc - first_init), 512'd66);
    blk_valid = 0;
    wait_done(200);
    chk("count_4", {480'd0, blk_count}, 512'd4);
    step();

    // Reset in the middle of the rounds abandons the block.
    rand_rdy = 1; blk_valid = 1;
    step();
    blk_valid = 0;
    run_to_round(30, 500);
    rand_rdy = 0; w_ready = 1;
    saw_done = 0;
    reset_n = 0;
    step();
    reset_n = 1;
    step();
    step();
    chk("rst_no_done", {511'd0, saw_done}, 512'd0);
    chk("rst_count", {480'd0, blk_count}, 512'd0);

`ifdef SHA256_W_CTRL_ABORT_EN
    blk_valid = 1;
    step();
    blk_valid = 0;
    run_to_round(10, 100);
    saw_done = 0;
    abort = 1;
    step();
    abort = 0;
    step();
    chk("abort_no_done", {511'd0, saw_done}, 512'd0);
    chk("abort_count", {480'd0, blk_count}, 512'd0);
    saw_init = 0;
    abort = 1; blk_valid = 1;
    step();
    abort = 0; blk_valid = 0;
    chk("abort_idle_accept", {511'd0, saw_init}, 512'd1);
    wait_done(200);
    chk("abort_idle_count", {480'd0, blk_count}, 512'd1);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
